dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 117 +++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory responder: one request in flight, fixed wait states,
// registered response held until the requester consumes it.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DepthWords = 30'(DEPTH_WORDS);
  localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} stateE;

  stateE       stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic        writeQ;
  logic [31:0] addrQ, wdataQ;
  logic [31:0] rdataQ;
  logic        errQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, consume, enterResp;
  logic             curWrite, curErr, memWe;
  logic [31:0]      curAddr, curWdata;
  logic [AddrW-1:0] curIdx;

  assign accept  = (stateQ == StIdle) && req_valid;
  assign consume = (stateQ == StResp) && resp_ready;

  // With no wait states the access completes on the accept edge itself, so the
  // live request fields are used instead of the latched copies.
  assign curWrite = (stateQ == StIdle) ? req_write : writeQ;
  assign curAddr  = (stateQ == StIdle) ? req_addr  : addrQ;
  assign curWdata = (stateQ == StIdle) ? req_wdata : wdataQ;
  assign curIdx   = curAddr[AddrW+1:2];
  assign curErr   = (curAddr[1:0] != 2'b00) || (curAddr[31:2] >= DepthWords);

  assign enterResp = (accept && (WaitCnt == 4'd0)) || ((stateQ == StWait) && (cntQ == 4'd1));
  // Gate on reset so a request presented during reset can never commit a store.
  assign memWe     = enterResp && curWrite && !curErr && reset;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (req_valid) begin
          if (WaitCnt == 4'd0) begin
            stateD = StResp;
          end else begin
            stateD = StWait;
            cntD   = WaitCnt;
          end
        end
      end
      StWait: begin
        cntD = cntQ - 4'd1;
        if (cntQ == 4'd1) stateD = StResp;
      end
      StResp: begin
        if (resp_ready) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
      writeQ <= 1'b0;
      addrQ  <= 32'd0;
      wdataQ <= 32'd0;
      rdataQ <= 32'd0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (accept) begin
        writeQ <= req_write;
        addrQ  <= req_addr;
        wdataQ <= req_wdata;
      end
      if (enterResp) begin
        errQ   <= curErr;
        rdataQ <= (curWrite || curErr) ? 32'd0 : mem[curIdx];
      end else if (consume) begin
        errQ   <= 1'b0;
        rdataQ <= 32'd0;
      end
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (memWe) mem[curIdx] <= curWdata;
  end

  assign req_ready  = (stateQ == StIdle);
  assign resp_valid = (stateQ == StResp);
  assign resp_rdata = rdataQ;
  assign resp_err   = errQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, per-DUT monitors pop and compare.
// Unit A runs with two wait states, unit B with none.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acceptEdge;
  } expT;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic        reqValidA = 1'b0, reqWriteA = 1'b0, respReadyA = 1'b1;
  logic [31:0] reqAddrA = '0, reqWdataA = '0;
  logic        reqReadyA, respValidA, respErrA;
  logic [31:0] respRdataA;

  logic        reqValidB = 1'b0, reqWriteB = 1'b0, respReadyB = 1'b1;
  logic [31:0] reqAddrB = '0, reqWdataB = '0;
  logic        reqReadyB, respValidB, respErrB;
  logic [31:0] respRdataB;

  expT qA[$];
  expT qB[$];

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dutA (
    .clk       (clk),
    .reset     (rstN),
    .req_valid (reqValidA),
    .req_write (reqWriteA),
    .req_addr  (reqAddrA),
    .req_wdata (reqWdataA),
    .req_ready (reqReadyA),
    .resp_valid(respValidA),
    .resp_ready(respReadyA),
    .resp_rdata(respRdataA),
    .resp_err  (respErrA)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dutB (
    .clk       (clk),
    .reset     (rstN),
    .req_valid (reqValidB),
    .req_write (reqWriteB),
    .req_addr  (reqAddrB),
    .req_wdata (reqWdataB),
    .req_ready (reqReadyB),
    .resp_valid(respValidB),
    .resp_ready(respReadyB),
    .resp_rdata(respRdataB),
    .resp_err  (respErrB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Latency counts the accept edge as edge 1: A responds on edge 3, B on edge 1.
  logic        prevA = 1'b0, heldErrA = 1'b0;
  logic [31:0] heldRdataA = '0;
  always @(negedge clk) begin
    expT e;
    if (respValidA && !prevA) begin
      vectors++;
      if (qA.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected response A: rdata %h with nothing outstanding", respRdataA);
      end else begin
        vectors--;
        e = qA.pop_front();
        check("rdata A", respRdataA, e.rdata);
        check("err A", 32'(respErrA), 32'(e.err));
        check("latency A", 32'(cyc - e.acceptEdge + 1), 32'd3);
      end
    end else if (respValidA && prevA) begin
      check("hold rdata A", respRdataA, heldRdataA);
      check("hold err A", 32'(respErrA), 32'(heldErrA));
    end
    prevA      <= respValidA;
    heldRdataA <= respRdataA;
    heldErrA   <= respErrA;
  end

  logic prevB = 1'b0;
  always @(negedge clk) begin
    expT e;
    if (respValidB && !prevB) begin
      vectors++;
      if (qB.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected response B: rdata %h with nothing outstanding", respRdataB);
      end else begin
        vectors--;
        e = qB.pop_front();
        check("rdata B", respRdataB, e.rdata);
        check("err B", 32'(respErrB), 32'(e.err));
        check("latency B", 32'(cyc - e.acceptEdge + 1), 32'd1);
      end
    end
    prevB <= respValidB;
  end

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic issue(input bit selB, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] expRdata,
                       input bit expErr, input bit track, output int acc);
    int  guard = 0;
    expT e;
    acc = -1;
    while (!(selB ? reqReadyB : reqReadyA) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL issue timeout: req_ready got 0, expected 1");
      return;
    end
    e.rdata      = expRdata;
    e.err        = expErr;
    e.acceptEdge = cyc + 1;
    acc          = cyc + 1;
    if (selB) begin
      reqValidB = 1'b1; reqWriteB = wr; reqAddrB = addr; reqWdataB = wdata;
      if (track) qB.push_back(e);
    end else begin
      reqValidA = 1'b1; reqWriteA = wr; reqAddrA = addr; reqWdataA = wdata;
      if (track) qA.push_back(e);
    end
    @(negedge clk);
    reqValidA = 1'b0;
    reqValidB = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((qA.size() != 0 || qB.size() != 0 || respValidA || respValidB) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain outstanding", 32'(qA.size() + qB.size()), 32'd0);
  endtask

  initial begin
    int acc, accS, accL, g;

    #1;
    check("reset req_ready A", 32'(reqReadyA), 32'd1);
    check("reset resp_valid A", 32'(respValidA), 32'd0);
    check("reset rdata A", respRdataA, 32'd0);
    check("reset err A", 32'(respErrA), 32'd0);
    check("reset req_ready B", 32'(reqReadyB), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    // Store then load, in-range and error cases, last word.
    issue(0, 1, 32'h10,  32'hDEADBEEF, 32'h0,        0, 1, acc);
    issue(0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1, acc);
    issue(0, 1, 32'h0,   32'h11111111, 32'h0,        0, 1, acc);
    issue(0, 0, 32'h13,  32'h0,        32'h0,        1, 1, acc);
    issue(0, 0, 32'h400, 32'h0,        32'h0,        1, 1, acc);
    issue(0, 1, 32'h401, 32'hFFFFFFFF, 32'h0,        1, 1, acc);
    issue(0, 0, 32'h0,   32'h0,        32'h11111111, 0, 1, acc);
    issue(0, 1, 32'h3FC, 32'h5A5A5A5A, 32'h0,        0, 1, acc);
    issue(0, 0, 32'h3FC, 32'h0,        32'h5A5A5A5A, 0, 1, acc);
    drain();

    // Backpressure with a stray store request that must be ignored.
    respReadyA = 1'b0;
    issue(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, acc);
    g = 0;
    while (!respValidA && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("bp resp_valid rise", 32'(respValidA), 32'd1);
    for (int i = 0; i < 5; i++) begin
      reqValidA = 1'b1; reqWriteA = 1'b1; reqAddrA = 32'h10; reqWdataA = 32'hBAD0BAD0;
      @(negedge clk);
      check("bp req_ready", 32'(reqReadyA), 32'd0);
      check("bp resp_valid", 32'(respValidA), 32'd1);
    end
    reqValidA  = 1'b0;
    respReadyA = 1'b1;
    @(negedge clk);
    check("consume resp_valid", 32'(respValidA), 32'd0);
    check("consume req_ready", 32'(reqReadyA), 32'd1);
    check("consume rdata", respRdataA, 32'd0);
    check("consume err", 32'(respErrA), 32'd0);
    issue(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, acc);
    drain();

    // Reset mid-wait abandons a store; storage survives reset.
    issue(0, 1, 32'h20, 32'hCAFEF00D, 32'h0, 0, 1, acc);
    issue(0, 1, 32'h20, 32'h12345678, 32'h0, 0, 0, acc);
    rstN = 1'b0;
    #1;
    check("mid-wait reset req_ready", 32'(reqReadyA), 32'd1);
    check("mid-wait reset resp_valid", 32'(respValidA), 32'd0);
    check("mid-wait reset rdata", respRdataA, 32'd0);
    check("mid-wait reset err", 32'(respErrA), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    issue(0, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1, acc);
    check("accept right after reset", 32'(acc - cyc), 32'd0);
    drain();

    // Zero wait states: back-to-back store/load to the last word.
    issue(1, 1, 32'h3FC, 32'hA5A5A5A5, 32'h0,        0, 1, accS);
    issue(1, 0, 32'h3FC, 32'h0,        32'hA5A5A5A5, 0, 1, accL);
    check("throughput B", 32'(accL - accS), 32'd2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
